// File: rtl/modinv_helper_reduce_precalc_pw.sv
// Word-serial precalc step for the binary modular invertor.
// Sweeps the buffers twice. The UP pass goes LSW->MSW and computes r = s +/- q.
// The DOWN pass goes MSW->LSW and computes u = s >> 1 and v = r >> 1.
// It reports the s_is_odd, k_is_nul and r_is_neg flags to the invertor FSM.
// All buffer memories are synchronous-read with a 1-cycle latency, so read data
// for the word addressed at counter value c arrives at counter value c+1.
module modinv_helper_reduce_precalc_pw #(
  parameter int WORD_W            = 32,
  parameter int OPERAND_NUM_WORDS = 8,
  parameter int OPERAND_ADDR_BITS = 3,
  parameter int BUFFER_NUM_WORDS  = 9,
  parameter int BUFFER_ADDR_BITS  = 4,
  parameter int K_NUM_BITS        = 10
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  output logic                         rdy,
  input  logic                         mode,
  input  logic [K_NUM_BITS-1:0]        k,
  output logic                         s_is_odd,
  output logic                         k_is_nul,
  output logic                         r_is_neg,
  output logic [BUFFER_ADDR_BITS-1:0]  s_addr,
  input  logic [WORD_W-1:0]            s_din,
  output logic [OPERAND_ADDR_BITS-1:0] q_addr,
  input  logic [WORD_W-1:0]            q_din,
  output logic [BUFFER_ADDR_BITS-1:0]  r_addr,
  input  logic [WORD_W-1:0]            r_din,
  output logic                         r_wren,
  output logic [WORD_W-1:0]            r_dout,
  output logic [BUFFER_ADDR_BITS-1:0]  u_addr,
  output logic [BUFFER_ADDR_BITS-1:0]  v_addr,
  output logic                         u_wren,
  output logic                         v_wren,
  output logic [WORD_W-1:0]            u_dout,
  output logic [WORD_W-1:0]            v_dout
);

  // Counter needs to reach N itself, one beyond the last address.
  localparam int CNT_W = BUFFER_ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(BUFFER_NUM_WORDS);
  localparam logic [CNT_W-1:0] N_M1   = CNT_W'(BUFFER_NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] OP_N   = CNT_W'(OPERAND_NUM_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN, ST_DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              start;
  logic              mode_r;
  logic              rd_phase, up_proc, dn_proc, dn_first;
  logic [CNT_W-1:0]  up_wr_idx, dn_rd_idx, dn_wr_idx;
  logic [WORD_W-1:0] q_eff, addend;
  logic [WORD_W:0]   sum_p1;
  logic              cy_p1, hs_p1, hr_p1;
  logic              hs, hr;

  // One word of the multiword add; carry-out lands in the top bit.
  function automatic logic [WORD_W:0] add_word(input logic [WORD_W-1:0] a,
                                               input logic [WORD_W-1:0] b,
                                               input logic              ci);
    return {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, ci};
  endfunction

  // One word of the multiword right shift; fill is the bit shifted in at the top.
  function automatic logic [WORD_W-1:0] shr_word(input logic              fill,
                                                 input logic [WORD_W-1:0] w);
    return {fill, w[WORD_W-1:1]};
  endfunction

  assign start     = ena & rdy;
  assign rd_phase  = (cnt < N_LAST);
  assign up_proc   = (state == ST_UP)   && (cnt != '0);
  assign dn_proc   = (state == ST_DOWN) && (cnt != '0);
  assign dn_first  = (state == ST_DOWN) && (cnt == CNT_W'(1));
  assign up_wr_idx = cnt - CNT_W'(1);
  assign dn_rd_idx = N_M1 - cnt;
  assign dn_wr_idx = N_LAST - cnt;

  // Words of q beyond its length read as zero; SUB adds the one's complement.
  assign q_eff  = (cnt <= OP_N) ? q_din : '0;
  assign addend = mode_r ? ~q_eff : q_eff;
  assign sum_p1 = add_word(s_din, addend, cy_p1);

  // The MSW gets a zero fill (logical) or r's sign (arithmetic, SUB only);
  // every later word takes bit 0 of the word read just before it.
  assign hs = dn_first ? 1'b0 : hs_p1;
  assign hr = dn_first ? (mode_r & r_din[WORD_W-1]) : hr_p1;

  // Next-state logic: IDLE -> UP (c=0..N) -> DOWN (c=0..N) -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: if (start) begin
        state_nxt = ST_UP;
        cnt_nxt   = '0;
      end
      ST_UP: if (cnt == N_LAST) begin
        state_nxt = ST_DOWN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
      ST_DOWN: if (cnt == N_LAST) begin
        state_nxt = ST_DONE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Control state, start-time captures and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rdy      <= 1'b1;
      mode_r   <= 1'b0;
      k_is_nul <= 1'b0;
      s_is_odd <= 1'b0;
      r_is_neg <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rdy   <= (state == ST_IDLE) && !start;
      if (start) begin
        mode_r   <= mode;
        k_is_nul <= (k == '0);
      end
      if ((state == ST_UP) && (cnt == CNT_W'(1)))
        s_is_odd <= s_din[0];
      if (dn_first)
        r_is_neg <= mode_r & r_din[WORD_W-1];
    end
  end

  // ---- stage p1: word-to-word carry and shift-in bits ----
  // Inter-word datapath state; the carry is seeded with mode at start.
  always_ff @(posedge clk) begin
    if (start)
      cy_p1 <= mode;
    else if (up_proc)
      cy_p1 <= sum_p1[WORD_W];
    if (dn_proc) begin
      hs_p1 <= s_din[0];
      hr_p1 <= r_din[0];
    end
  end

  // Memory addresses, write enables and write data for the current pass.
  always_comb begin
    s_addr = '0;
    q_addr = '0;
    r_addr = '0;
    u_addr = '0;
    v_addr = '0;
    r_wren = 1'b0;
    u_wren = 1'b0;
    v_wren = 1'b0;
    r_dout = '0;
    u_dout = '0;
    v_dout = '0;
    case (state)
      ST_UP: begin
        if (rd_phase) s_addr = BUFFER_ADDR_BITS'(cnt);
        if (cnt < OP_N) q_addr = OPERAND_ADDR_BITS'(cnt);
        if (up_proc) begin
          r_addr = BUFFER_ADDR_BITS'(up_wr_idx);
          r_wren = 1'b1;
          r_dout = sum_p1[WORD_W-1:0];
        end
      end
      ST_DOWN: begin
        if (rd_phase) begin
          s_addr = BUFFER_ADDR_BITS'(dn_rd_idx);
          r_addr = BUFFER_ADDR_BITS'(dn_rd_idx);
        end
        if (dn_proc) begin
          u_addr = BUFFER_ADDR_BITS'(dn_wr_idx);
          v_addr = BUFFER_ADDR_BITS'(dn_wr_idx);
          u_wren = 1'b1;
          v_wren = 1'b1;
          u_dout = shr_word(hs, s_din);
          v_dout = shr_word(hr, r_din);
        end
      end
      default: ;
    endcase
  end

endmodule
